id_ex_register: RTL

- ID/EX pipeline register directly downstream of the decode register file.
- Captures both read operands, register addresses, immediate and control bits each cycle, and presents them to execute.
- Performs WB-to-ID bypass, because the register file's posedge write is not visible to a same-cycle combinational read.
- Detects load-use hazards, inserts one bubble, and tells fetch/decode to hold.

---
 rtl/id_ex_register_pkg.sv | 34 +++
 rtl/id_ex_register_load_use_detector.sv | 24 ++
 rtl/id_ex_register.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle bit
// positions, default widths and the per-edge update priority.
package id_ex_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int CTRL_WIDTH_DEF = 8;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_USE_RS1   = 1;
  localparam int CTRL_USE_RS2   = 2;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_ALU_LSB   = 5;
  localparam int CTRL_ALU_MSB   = 7;

  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'd0,
    UPD_FLUSH   = 2'd1,
    UPD_HOLD    = 2'd2,
    UPD_BUBBLE  = 2'd3
  } upd_e;

  // Flush kills everything, a stalled EX must keep its instruction, and a
  // load-use bubble only matters when EX is free to advance.
  function automatic upd_e next_action(input logic flush, input logic stall,
                                       input logic load_use);
    if (flush)         return UPD_FLUSH;
    else if (stall)    return UPD_HOLD;
    else if (load_use) return UPD_BUBBLE;
    else               return UPD_CAPTURE;
  endfunction

endpackage

// File: rtl/id_ex_register_load_use_detector.sv
// Combinational load-use hazard detection between the decode slot and a load
// sitting in execute; shared with the fetch stage.
module load_use_detector #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  id_valid,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use  = id_valid && ex_valid && ex_mem_read && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with WB-to-ID bypass, load-use bubble insertion and
// EX-stall hold. Define ID_EX_HAZARD_COUNTERS_EN to add bubble/stall counters.
module id_ex_register
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_read_data1,
  input  logic [DATA_WIDTH-1:0] id_read_data2,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_write_address,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_read_data1,
  output logic [DATA_WIDTH-1:0] ex_read_data2,
  output logic [ADDR_WIDTH-1:0] ex_rs1,
  output logic [ADDR_WIDTH-1:0] ex_rs2,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
`ifdef ID_EX_HAZARD_COUNTERS_EN
  output logic [15:0]           bubble_count,
  output logic [15:0]           stall_count,
`endif
  output logic                  id_hold
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_read_data1;
  logic [DATA_WIDTH-1:0] r_read_data2;
  logic [ADDR_WIDTH-1:0] r_rs1;
  logic [ADDR_WIDTH-1:0] r_rs2;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [CTRL_WIDTH-1:0] r_ctrl;

  logic                  w_load_use;
  upd_e                  w_action;
  logic [DATA_WIDTH-1:0] w_cap_data1;
  logic [DATA_WIDTH-1:0] w_cap_data2;
  logic [DATA_WIDTH-1:0] w_hold_data1;
  logic [DATA_WIDTH-1:0] w_hold_data2;

  load_use_detector #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_load_use_detector (
    .id_valid    (id_valid),
    .id_use_rs1  (id_ctrl[CTRL_USE_RS1]),
    .id_use_rs2  (id_ctrl[CTRL_USE_RS2]),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (r_valid),
    .ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .ex_rd       (r_rd),
    .load_use    (w_load_use)
  );

  assign w_action = next_action(flush, ex_stall, w_load_use);
  assign id_hold  = w_load_use | ex_stall;

  // The regfile write lands on the same edge we sample, so forward WB data.
  assign w_cap_data1 = (wb_write_enable && wb_write_address == id_rs1) ? wb_write_data : id_read_data1;
  assign w_cap_data2 = (wb_write_enable && wb_write_address == id_rs2) ? wb_write_data : id_read_data2;

  // A held instruction must still observe writebacks that complete meanwhile.
  assign w_hold_data1 = (r_valid && wb_write_enable && wb_write_address == r_rs1) ? wb_write_data : r_read_data1;
  assign w_hold_data2 = (r_valid && wb_write_enable && wb_write_address == r_rs2) ? wb_write_data : r_read_data2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_ctrl       <= '0;
    end else begin
      unique case (w_action)
        UPD_FLUSH, UPD_BUBBLE: begin
          r_valid      <= 1'b0;
          r_read_data1 <= '0;
          r_read_data2 <= '0;
          r_rs1        <= '0;
          r_rs2        <= '0;
          r_rd         <= '0;
          r_imm        <= '0;
          r_ctrl       <= '0;
        end
        UPD_HOLD: begin
          r_read_data1 <= w_hold_data1;
          r_read_data2 <= w_hold_data2;
        end
        UPD_CAPTURE: begin
          r_valid      <= id_valid;
          r_read_data1 <= w_cap_data1;
          r_read_data2 <= w_cap_data2;
          r_rs1        <= id_rs1;
          r_rs2        <= id_rs2;
          r_rd         <= id_rd;
          r_imm        <= id_imm;
          r_ctrl       <= id_valid ? id_ctrl : '0;
        end
      endcase
    end
  end

`ifdef ID_EX_HAZARD_COUNTERS_EN
  logic [15:0] r_bubble_count;
  logic [15:0] r_stall_count;

  // Counters wrap naturally; flush bubbles are deliberately not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_count <= '0;
      r_stall_count  <= '0;
    end else begin
      if (w_action == UPD_BUBBLE)
        r_bubble_count <= r_bubble_count + 16'd1;
      if (ex_stall && r_valid)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bubble_count = r_bubble_count;
  assign stall_count  = r_stall_count;
`endif

  assign ex_valid      = r_valid;
  assign ex_read_data1 = r_read_data1;
  assign ex_read_data2 = r_read_data2;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_imm        = r_imm;
  assign ex_ctrl       = r_ctrl;

endmodule
